// File: rtl/vga_plot_framebuffer_if.sv
// vga_plot_framebuffer_if: pixel-plot bus from a drawing FSM to the framebuffer.
`default_nettype none

interface vga_plot_framebuffer_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);
endinterface

`default_nettype wire

// File: rtl/vga_plot_framebuffer.sv
// vga_plot_framebuffer: 160x120x3 framebuffer with plot-port writes and a
// 640x480@60 VGA scan-out, each stored pixel drawn as a 4x4 block.
`default_nettype none

module vga_plot_framebuffer #(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic                          clk,
    input  logic                          rst,
    vga_plot_framebuffer_if.slave         plot_if,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic                          VGA_BLANK,
    output logic                          VGA_CLK,
    output logic                          frame_start
);

    localparam int          FB_DEPTH = FB_W * FB_H;
    localparam logic [14:0] FB_W15   = 15'(FB_W);
    localparam logic [7:0]  X_LIM    = 8'(FB_W);
    localparam logic [6:0]  Y_LIM    = 7'(FB_H);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS    = 10'd640;
    localparam logic [9:0]  V_VIS    = 10'd480;
    localparam logic [9:0]  H_SYNC_S = 10'd656;
    localparam logic [9:0]  H_SYNC_E = 10'd751;
    localparam logic [9:0]  V_SYNC_S = 10'd490;
    localparam logic [9:0]  V_SYNC_E = 10'd491;

    logic [2:0] mem_q [FB_DEPTH];

    // ---------------- write side ----------------
    logic        w1_vld_q, w1_vld_d;
    logic [14:0] w1_addr_q, w1_addr_d;
    logic [2:0]  w1_col_q, w1_col_d;

    always_comb begin
        w1_vld_d  = plot_if.vga_plot && (plot_if.vga_x < X_LIM) && (plot_if.vga_y < Y_LIM);
        w1_addr_d = {8'b0, plot_if.vga_y} * FB_W15 + {7'b0, plot_if.vga_x};
        w1_col_d  = plot_if.vga_colour;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w1_vld_q <= 1'b0;
        end else begin
            w1_vld_q <= w1_vld_d;
        end
        w1_addr_q <= w1_addr_d;
        w1_col_q  <= w1_col_d;
    end

    // A write held in W1 when reset arrives is dropped rather than committed.
    always_ff @(posedge clk) begin
        if (w1_vld_q && !rst) begin
            mem_q[w1_addr_q] <= w1_col_q;
        end
    end

    // ---------------- timing generator ----------------
    logic       tick_q;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // ---------------- scan-out pipeline ----------------
    logic        w_vis, w_hs, w_vs;
    logic [14:0] w_raddr;

    always_comb begin
        w_vis   = (h_q < H_VIS) && (v_q < V_VIS);
        w_raddr = w_vis ? ({7'b0, v_q[9:2]} * FB_W15 + {7'b0, h_q[9:2]}) : 15'd0;
        w_hs    = !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
        w_vs    = !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
    end

    logic        s1_vis_q, s1_hs_q, s1_vs_q;
    logic [14:0] s1_raddr_q;
    logic        s2_vis_q, s2_hs_q, s2_vs_q;
    logic [2:0]  s2_data_q;
    logic [7:0]  red_q, grn_q, blu_q;
    logic        hs_q, vs_q, blank_q, fs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= 1'b0;
            h_q        <= 10'd0;
            v_q        <= 10'd0;
            s1_vis_q   <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_raddr_q <= 15'd0;
            s2_vis_q   <= 1'b0;
            s2_hs_q    <= 1'b1;
            s2_vs_q    <= 1'b1;
            s2_data_q  <= 3'd0;
            red_q      <= 8'd0;
            grn_q      <= 8'd0;
            blu_q      <= 8'd0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            h_q    <= h_d;
            v_q    <= v_d;
            // Counters sit at 0,0 for a tick=0 cycle exactly once per frame.
            fs_q   <= !tick_q && (h_q == 10'd0) && (v_q == 10'd0);
            if (tick_q) begin
                s1_vis_q   <= w_vis;
                s1_hs_q    <= w_hs;
                s1_vs_q    <= w_vs;
                s1_raddr_q <= w_raddr;
                s2_vis_q   <= s1_vis_q;
                s2_hs_q    <= s1_hs_q;
                s2_vs_q    <= s1_vs_q;
                s2_data_q  <= mem_q[s1_raddr_q];
                red_q      <= {8{s2_vis_q & s2_data_q[2]}};
                grn_q      <= {8{s2_vis_q & s2_data_q[1]}};
                blu_q      <= {8{s2_vis_q & s2_data_q[0]}};
                hs_q       <= s2_hs_q;
                vs_q       <= s2_vs_q;
                blank_q    <= s2_vis_q;
            end
        end
    end

    assign VGA_R       = red_q;
    assign VGA_G       = grn_q;
    assign VGA_B       = blu_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_CLK     = tick_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire
